// File: rtl/vram_writer_pkg.sv
// Shared video-path definitions: SRAM widths, writer FSM states and the
// host command record carried through the command FIFO.
package vram_writer_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wrState_t;

    typedef struct packed {
        logic              setaddr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        be;
    } hostCmd_t;

    localparam int CMD_W = $bits(hostCmd_t);
endpackage

// File: rtl/vram_writer_if.sv
// Host command handshake into the VRAM writer.
interface vram_writer_if;
    import vram_writer_pkg::*;

    logic              host_valid;
    logic              host_ready;
    logic              host_setaddr;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic [1:0]        host_be;

    modport master (output host_valid, host_setaddr, host_addr, host_data, host_be,
                    input  host_ready);
    modport slave  (input  host_valid, host_setaddr, host_addr, host_data, host_be,
                    output host_ready);
endinterface

// File: rtl/vram_writer_cmd_fifo.sv
// Single-clock command FIFO; DEPTH must be a power of two so pointers wrap freely.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [PW:0]      count;
    logic             doPush, doPop;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
        end
    end
endmodule

// File: rtl/vram_writer.sv
// Drains host commands into the shared SRAM: pointer loads take one cycle,
// data writes run a fixed 4-cycle IDLE/SETUP/STROBE/HOLD sequence.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    vram_writer_if.slave      host,
    input  logic              bus_busy,
    output logic              bus_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              ram_lb,
    output logic              ram_hb,
    output logic              idle,
    output logic [15:0]       writes_done
);
    wrState_t          state;
    hostCmd_t          cmdIn, head;
    logic [CMD_W-1:0]  headBits;
    logic              fifoFull, fifoEmpty, pop;
    logic [ADDR_W-1:0] ptr;

    assign cmdIn = {host.host_setaddr, host.host_addr, host.host_data, host.host_be};
    assign head  = hostCmd_t'(headBits);
    assign host.host_ready = !fifoFull;

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) uFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host.host_valid),
        .din   (cmdIn),
        .full  (fifoFull),
        .pop   (pop),
        .dout  (headBits),
        .empty (fifoEmpty)
    );

    // Pointer loads never touch the SRAM, so only data writes wait on the reader.
    assign pop    = (state == IDLE) && !fifoEmpty && (head.setaddr || !bus_busy);
    assign idle   = fifoEmpty && (state == IDLE);
    assign ram_oe = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            writes_done <= '0;
            ram_addr    <= '0;
            ram_dout    <= '0;
            ram_ce      <= 1'b0;
            ram_we      <= 1'b0;
            ram_lb      <= 1'b0;
            ram_hb      <= 1'b0;
            bus_req     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    if (head.setaddr) begin
                        ptr <= head.addr;
                    end else begin
                        ram_addr <= ptr;
                        ram_dout <= head.data;
                        ram_lb   <= head.be[0];
                        ram_hb   <= head.be[1];
                        ram_ce   <= 1'b1;
                        bus_req  <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    ram_we <= 1'b1;
                    state  <= STROBE;
                end
                STROBE: begin
                    ram_we <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: begin
                    ram_ce      <= 1'b0;
                    bus_req     <= 1'b0;
                    ptr         <= ptr + 1'b1;
                    writes_done <= writes_done + 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: write sequencing, FIFO back-pressure,
// bus arbitration, pointer wrap, byte enables and mid-cycle reset.
module tb_vram_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_busy;
    logic        bus_req, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, idle;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] writes_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [17:0] logAddr[$];
    logic [15:0] logData[$];
    int          logCyc[$];

    vram_writer_if hif ();

    vram_writer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (hif),
        .bus_busy    (bus_busy),
        .bus_req     (bus_req),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .ram_ce      (ram_ce),
        .ram_oe      (ram_oe),
        .ram_we      (ram_we),
        .ram_lb      (ram_lb),
        .ram_hb      (ram_hb),
        .idle        (idle),
        .writes_done (writes_done)
    );

    always #5 clk = ~clk;

    // Log every strobe cycle, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            logAddr.push_back(ram_addr);
            logData.push_back(ram_dout);
            logCyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sa, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be);
        bit done = 1'b0;
        hif.host_valid = 1'b1; hif.host_setaddr = sa;
        hif.host_addr = a; hif.host_data = d; hif.host_be = be;
        for (int i = 0; i < 60 && !done; i++) begin
            if (hif.host_ready) done = 1'b1;
            tick();
        end
        hif.host_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic waitWe();
        int n = 0;
        while (!ram_we && n < 100) begin tick(); n++; end
        if (!ram_we) chk("we_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!idle && n < 200) begin tick(); n++; end
        if (!idle) chk("idle_timeout", 0, 1);
    endtask

    task automatic clearLog();
        logAddr.delete(); logData.delete(); logCyc.delete();
    endtask

    initial begin
        bit ok;
        logic [2:0] weSeq;
        rst_n = 1'b0; bus_busy = 1'b0;
        hif.host_valid = 1'b0; hif.host_setaddr = 1'b0;
        hif.host_addr = '0; hif.host_data = '0; hif.host_be = '0;
        tick(); tick();
        chk("rst_idle", idle, 1);
        chk("rst_ce_we", {ram_ce, ram_we, ram_lb, ram_hb, bus_req, ram_oe}, 0);
        chk("rst_addr_dout", {ram_addr, ram_dout}, 0);
        chk("rst_wdone", writes_done, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("rst_ready", hif.host_ready, 1);

        // Pointer load then one full-width write, checked cycle by cycle
        push(1'b1, 18'h00100, 16'h0, 2'b00);
        push(1'b0, 18'h0, 16'hABCD, 2'b11);
        tick();
        chk("w1_setup", {ram_ce, ram_we, bus_req, ram_lb, ram_hb}, 5'b10111);
        chk("w1_setup_addr", ram_addr, 18'h00100);
        chk("w1_setup_dout", ram_dout, 16'hABCD);
        tick();
        chk("w1_strobe", {ram_ce, ram_we, ram_addr}, {2'b11, 18'h00100});
        tick();
        chk("w1_hold", {ram_ce, ram_we, ram_dout}, {2'b10, 16'hABCD});
        tick();
        chk("w1_end", {ram_ce, ram_we, bus_req, idle}, 4'b0001);
        chk("w1_wdone", writes_done, 1);
        push(1'b0, 18'h0, 16'h5555, 2'b11);
        waitWe();
        chk("w1_ptr_next", ram_addr, 18'h00101);
        waitIdle();
        chk("w1b_wdone", writes_done, 2);

        // Five back-to-back writes through a 4-deep FIFO
        clearLog();
        push(1'b1, 18'h02000, 16'h0, 2'b00);
        for (int i = 0; i < 5; i++) push(1'b0, 18'h0, 16'hA000 + 16'(i), 2'b11);
        chk("b2b_full_ready", hif.host_ready, 0);
        waitIdle();
        chk("b2b_count", logAddr.size(), 5);
        if (logAddr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("b2b_addr%0d", i), logAddr[i], 18'h02000 + 18'(i));
                chk($sformatf("b2b_data%0d", i), logData[i], 16'hA000 + 16'(i));
            end
            ok = 1'b1;
            for (int i = 1; i < 5; i++) if (logCyc[i] - logCyc[i-1] != 4) ok = 1'b0;
            chk("b2b_spacing4", ok, 1);
        end
        chk("b2b_wdone", writes_done, 7);

        // Reader holds the bus: no write may start until it lets go
        bus_busy = 1'b1;
        push(1'b1, 18'h00300, 16'h0, 2'b00);
        push(1'b0, 18'h0, 16'hBEEF, 2'b11);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ram_ce || ram_we || bus_req) ok = 1'b0;
            tick();
        end
        chk("busy_blocks", ok, 1);
        bus_busy = 1'b0;
        waitWe();
        chk("busy_addr", ram_addr, 18'h00300);
        bus_busy = 1'b1;
        tick();
        chk("busy_mid_hold", {ram_ce, bus_req}, 2'b11);
        tick();
        chk("busy_mid_done", {ram_ce, writes_done}, {1'b0, 16'd8});
        bus_busy = 1'b0;

        // Pointer wrap at the top of the SRAM
        clearLog();
        push(1'b1, 18'h3FFFF, 16'h0, 2'b00);
        push(1'b0, 18'h0, 16'h1111, 2'b11);
        push(1'b0, 18'h0, 16'h2222, 2'b11);
        waitIdle();
        chk("wrap_count", logAddr.size(), 2);
        if (logAddr.size() == 2) begin
            chk("wrap_addr0", logAddr[0], 18'h3FFFF);
            chk("wrap_addr1", logAddr[1], 18'h00000);
        end

        // Low-byte only, then no bytes at all
        push(1'b0, 18'h0, 16'h1234, 2'b01);
        for (int n = 0; n < 20 && !ram_ce; n++) tick();
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!(ram_ce && ram_lb && !ram_hb && ram_addr == 18'h00001 && ram_dout == 16'h1234))
                ok = 1'b0;
            weSeq[2-i] = ram_we;
            tick();
        end
        chk("be01_stable", ok, 1);
        chk("be01_we_pulse", weSeq, 3'b010);
        clearLog();
        push(1'b0, 18'h0, 16'h7777, 2'b00);
        waitWe();
        chk("be00_strobes", {ram_ce, ram_lb, ram_hb, ram_addr}, {3'b100, 18'h00002});
        waitIdle();
        chk("be00_wdone", writes_done, 12);

        // Reset in the middle of a strobe, with commands still queued
        push(1'b1, 18'h00040, 16'h0, 2'b00);
        push(1'b0, 18'h0, 16'hC001, 2'b11);
        push(1'b0, 18'h0, 16'hC002, 2'b11);
        push(1'b0, 18'h0, 16'hC003, 2'b11);
        waitWe();
        chk("mid_pre_we", {ram_we, ram_addr}, {1'b1, 18'h00040});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {ram_we, ram_ce, bus_req}, 3'b000);
        chk("mid_rst_idle", idle, 1);
        @(negedge clk); rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ram_ce || ram_we) ok = 1'b0;
        end
        chk("mid_fifo_discard", ok, 1);
        chk("mid_after", {idle, hif.host_ready, writes_done, ram_addr}, {2'b11, 16'd0, 18'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
